// File: rtl/chorus_delay_controller.sv
// Per-sample sequencer for the chorus delay line: accepts a sample, strobes the delay buffer,
// mixes the dry/wet words it returns and sweeps the delay with a triangle LFO.
module chorus_delay_controller #(
   parameter int unsigned BUFFER_SIZE = 44100,
   parameter int unsigned MIN_DELAY   = 441,
   parameter int unsigned MAX_DELAY   = 1323
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] sample_in,
   input  logic        sample_in_valid,
   output logic        sample_in_ready,
   input  logic [15:0] lfo_div,
   input  logic [8:0]  mix,
   input  logic        bypass,
   output logic        buf_enable,
   output logic [15:0] buf_data_in,
   output logic [15:0] buf_delay,
   input  logic [15:0] buf_dry,
   input  logic [15:0] buf_wet,
   output logic [15:0] sample_out,
   output logic        sample_out_valid,
   input  logic        sample_out_ready,
   output logic [15:0] cur_delay
);

   // Keep the sweep inside the attached buffer even if MAX_DELAY is misconfigured.
   localparam int unsigned MAX_EFF = (MAX_DELAY < BUFFER_SIZE) ? MAX_DELAY : BUFFER_SIZE - 1;
   localparam logic [15:0] DMIN = 16'(MIN_DELAY);
   localparam logic [15:0] DMAX = 16'(MAX_EFF);
   localparam bit LFO_FIXED = (MIN_DELAY >= MAX_EFF);

   typedef enum logic [1:0] {IDLE, WRITE, CAPTURE, OUT} state_t;

   state_t             state;
   logic               lfo_up;
   logic [15:0]        lfo_cnt;

   logic [8:0]         m;
   logic signed [25:0] mix_sum;
   logic [15:0]        mix_res;
   logic [15:0]        lfo_cnt_d;
   logic [15:0]        delay_d;
   logic               up_d;

   assign sample_in_ready = (state == IDLE);

   // Convex combination; the arithmetic shift floors toward minus infinity.
   always_comb begin
      m       = (mix > 9'd256) ? 9'd256 : mix;
      mix_sum = 26'($signed(buf_dry)) * 26'($signed({1'b0, 9'd256 - m}))
              + 26'($signed(buf_wet)) * 26'($signed({1'b0, m}));
      mix_res = 16'(mix_sum >>> 8);
   end

   always_comb begin
      lfo_cnt_d = lfo_cnt;
      delay_d   = cur_delay;
      up_d      = lfo_up;
      if (lfo_div == 16'd0) begin
         lfo_cnt_d = 16'd0;
      end else if ({1'b0, lfo_cnt} + 17'd1 >= {1'b0, lfo_div}) begin
         lfo_cnt_d = 16'd0;
         if (LFO_FIXED) begin
            delay_d = DMIN;
         end else if (lfo_up) begin
            if (cur_delay >= DMAX) begin
               up_d    = 1'b0;
               delay_d = DMAX - 16'd1;
            end else begin
               delay_d = cur_delay + 16'd1;
            end
         end else begin
            if (cur_delay <= DMIN) begin
               up_d    = 1'b1;
               delay_d = DMIN + 16'd1;
            end else begin
               delay_d = cur_delay - 16'd1;
            end
         end
      end else begin
         lfo_cnt_d = lfo_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state            <= IDLE;
         buf_enable       <= 1'b0;
         buf_data_in      <= 16'd0;
         buf_delay        <= DMIN;
         cur_delay        <= DMIN;
         lfo_up           <= 1'b1;
         lfo_cnt          <= 16'd0;
         sample_out       <= 16'd0;
         sample_out_valid <= 1'b0;
      end else begin
         buf_enable <= 1'b0;
         case (state)
            IDLE: begin
               // The buffer only sees a new delay here, so it is stable across WRITE.
               buf_delay <= cur_delay;
               if (sample_in_valid) begin
                  buf_data_in <= sample_in;
                  buf_enable  <= 1'b1;
                  state       <= WRITE;
               end
            end
            WRITE: begin
               state <= CAPTURE;
            end
            CAPTURE: begin
               sample_out       <= bypass ? buf_dry : mix_res;
               sample_out_valid <= 1'b1;
               state            <= OUT;
            end
            OUT: begin
               if (sample_out_ready) begin
                  sample_out_valid <= 1'b0;
                  cur_delay        <= delay_d;
                  lfo_up           <= up_d;
                  lfo_cnt          <= lfo_cnt_d;
                  state            <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
